maze_world: RTL and testbench

- Environment/responder for the ant controller. It consumes the controller's `move` and `ph_drop` commands and produces the sensor inputs the controller reads: `ant_l`, `ant_r`, `hit`, `escape`, `ph_detected`.
- Holds a configurable wall map, the ant pose (x, y, heading) and a per-cell pheromone map.
- Sits opposite the ant controller in the maze testbench/top. It is the closed-loop partner for simulation and for FPGA demos.

---
 rtl/maze_world.sv | 147 ++++++++++++++
 tb/tb_maze_world.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/maze_world.sv
// Maze environment for the ant controller: wall map, ant pose and pheromone map.
// Turns move/ph_drop commands into the sensor signals the controller reads.
module maze_world #(
   parameter int         GRID_W    = 8,
   parameter int         GRID_H    = 8,
   parameter int         PH_WIDTH  = 2,
   parameter int         START_X   = 0,
   parameter int         START_Y   = 0,
   parameter int         START_DIR = 1,
   parameter int         EXIT_X    = 7,
   parameter int         EXIT_Y    = 7,
   parameter logic [1:0] HALT      = 2'b00,
   parameter logic [1:0] RIGHT     = 2'b01,
   parameter logic [1:0] LEFT      = 2'b10,
   parameter logic [1:0] FORWARD   = 2'b11,
   localparam int        NCELLS    = GRID_W * GRID_H,
   localparam int        AW        = $clog2(NCELLS),
   localparam int        XW        = $clog2(GRID_W),
   localparam int        YW        = $clog2(GRID_H)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run_en,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [3:0]          cfg_walls,
   input  logic [1:0]          move,
   input  logic [PH_WIDTH-1:0] ph_drop,
   output logic                ant_l,
   output logic                ant_r,
   output logic                hit,
   output logic                escape,
   output logic [PH_WIDTH-1:0] ph_detected,
   output logic [XW-1:0]       pos_x,
   output logic [YW-1:0]       pos_y,
   output logic [1:0]          heading,
   output logic [15:0]         step_cnt
);

   typedef enum logic [1:0] {S_CONFIG, S_RUN, S_DONE} state_t;

   localparam logic [PH_WIDTH-1:0] PH_MAX = '1;

   state_t              state;
   logic [3:0]          walls  [NCELLS];
   logic [PH_WIDTH-1:0] ph_map [NCELLS];

   logic [AW-1:0]       cur_idx;
   logic [3:0]          blocked;
   logic [XW-1:0]       nx;
   logic [YW-1:0]       ny;
   logic                at_exit;
   logic                nxt_exit;
   logic [PH_WIDTH:0]   ph_sum;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      cur_idx     = AW'(pos_y) * AW'(GRID_W) + AW'(pos_x);
      // Boundary edges are always blocked; the neighbour's opposite wall bit is never consulted.
      blocked[0]  = walls[cur_idx][0] | (pos_y == '0);
      blocked[1]  = walls[cur_idx][1] | (pos_x == XW'(GRID_W - 1));
      blocked[2]  = walls[cur_idx][2] | (pos_y == YW'(GRID_H - 1));
      blocked[3]  = walls[cur_idx][3] | (pos_x == '0);
      ant_r       = blocked[heading];
      ant_l       = blocked[heading - 2'd1];
      ph_detected = ph_map[cur_idx];
      ph_sum      = {1'b0, ph_map[cur_idx]} + {1'b0, ph_drop};
      nx          = pos_x;
      ny          = pos_y;
      if (move == FORWARD && !blocked[heading]) begin
         case (heading)
            2'd0:    ny = pos_y - YW'(1);
            2'd1:    nx = pos_x + XW'(1);
            2'd2:    ny = pos_y + YW'(1);
            default: nx = pos_x - XW'(1);
         endcase
      end
      at_exit  = (pos_x == XW'(EXIT_X)) && (pos_y == YW'(EXIT_Y));
      nxt_exit = (nx == XW'(EXIT_X)) && (ny == YW'(EXIT_Y));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_CONFIG;
         pos_x    <= XW'(START_X);
         pos_y    <= YW'(START_Y);
         heading  <= 2'(START_DIR);
         hit      <= 1'b0;
         escape   <= 1'b0;
         step_cnt <= '0;
         // NOTE: the maps are small register arrays that must read as empty after reset, so they are cleared here.
         for (int i = 0; i < NCELLS; i++) begin
            walls[i]  <= '0;
            ph_map[i] <= '0;
         end
      end else begin
         hit <= 1'b0;
         case (state)
            S_CONFIG: begin
               if (run_en) begin
                  state <= S_RUN;
               end else if (cfg_we && int'(cfg_addr) < NCELLS) begin
                  walls[cfg_addr] <= cfg_walls;
               end
            end
            S_RUN: begin
               if (!run_en) begin
                  state   <= S_CONFIG;
                  pos_x   <= XW'(START_X);
                  pos_y   <= YW'(START_Y);
                  heading <= 2'(START_DIR);
               end else if (at_exit) begin
                  state  <= S_DONE;
                  escape <= 1'b1;
               end else begin
                  // The drop lands on the pre-move cell even when FORWARD leaves it this cycle.
                  if (ph_drop != '0)
                     ph_map[cur_idx] <= ph_sum[PH_WIDTH] ? PH_MAX : ph_sum[PH_WIDTH-1:0];
                  case (move)
                     RIGHT: heading <= heading + 2'd1;
                     LEFT:  heading <= heading - 2'd1;
                     FORWARD: begin
                        if (blocked[heading]) begin
                           hit <= 1'b1;
                        end else begin
                           pos_x <= nx;
                           pos_y <= ny;
                           if (step_cnt != 16'hFFFF)
                              step_cnt <= step_cnt + 16'd1;
                           if (nxt_exit) begin
                              state  <= S_DONE;
                              escape <= 1'b1;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_DONE:  ;
            default: state <= S_CONFIG;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_world.sv
// Directed bench for maze_world: a vector table for the basic run plus
// hand-written sequences for config, async reset and the escape route.
module tb_maze_world;

   localparam logic [1:0] HALT    = 2'b00;
   localparam logic [1:0] RIGHT   = 2'b01;
   localparam logic [1:0] LEFT    = 2'b10;
   localparam logic [1:0] FORWARD = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_en;
   logic        cfg_we;
   logic [5:0]  cfg_addr;
   logic [3:0]  cfg_walls;
   logic [1:0]  move;
   logic [1:0]  ph_drop;
   logic        ant_l, ant_r, hit, escape;
   logic [1:0]  ph_detected;
   logic [2:0]  pos_x, pos_y;
   logic [1:0]  heading;
   logic [15:0] step_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   maze_world dut (
      .clk(clk), .rst_n(rst_n), .run_en(run_en), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_walls(cfg_walls), .move(move), .ph_drop(ph_drop),
      .ant_l(ant_l), .ant_r(ant_r), .hit(hit), .escape(escape),
      .ph_detected(ph_detected), .pos_x(pos_x), .pos_y(pos_y),
      .heading(heading), .step_cnt(step_cnt)
   );

   typedef struct {
      logic        run;
      logic [1:0]  mv;
      logic [1:0]  drop;
      logic [2:0]  x;
      logic [2:0]  y;
      logic [1:0]  h;
      logic        l;
      logic        r;
      logic        hit;
      logic        esc;
      logic [1:0]  ph;
      logic [15:0] st;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(input logic run, input logic [1:0] mv, input logic [1:0] drop,
                               input int x, input int y, input int h, input logic l, input logic r,
                               input logic ht, input logic esc, input int ph, input int st);
      vec_t v;
      v.run = run; v.mv = mv; v.drop = drop;
      v.x = 3'(x); v.y = 3'(y); v.h = 2'(h); v.l = l; v.r = r;
      v.hit = ht; v.esc = esc; v.ph = 2'(ph); v.st = 16'(st);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] m, input logic [1:0] d);
      run_en  = r;
      move    = m;
      ph_drop = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] obs();
      return {2'b00, pos_x, pos_y, heading, ant_l, ant_r, hit, escape, ph_detected, step_cnt};
   endfunction

   function automatic logic [31:0] pack(input vec_t v);
      return {2'b00, v.x, v.y, v.h, v.l, v.r, v.hit, v.esc, v.ph, v.st};
   endfunction

   initial begin
      // Empty 8x8 map, start (0,0) facing E.
      vecs[0]  = mk(1, HALT,    0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, LEFT,    0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      vecs[2]  = mk(1, RIGHT,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, RIGHT,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(1, RIGHT,   0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
      vecs[5]  = mk(1, RIGHT,   0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      vecs[6]  = mk(1, RIGHT,   0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1, HALT,    1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      vecs[8]  = mk(1, HALT,    1, 0, 0, 1, 1, 0, 0, 0, 2, 0);
      vecs[9]  = mk(1, HALT,    1, 0, 0, 1, 1, 0, 0, 0, 3, 0);
      vecs[10] = mk(1, HALT,    1, 0, 0, 1, 1, 0, 0, 0, 3, 0);
      vecs[11] = mk(1, FORWARD, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1);
      vecs[12] = mk(1, FORWARD, 2, 2, 0, 1, 1, 0, 0, 0, 0, 2);
      vecs[13] = mk(1, LEFT,    0, 2, 0, 0, 0, 1, 0, 0, 0, 2);
      vecs[14] = mk(1, LEFT,    0, 2, 0, 3, 0, 0, 0, 0, 0, 2);
      vecs[15] = mk(1, FORWARD, 0, 1, 0, 3, 0, 0, 0, 0, 2, 3);
      vecs[16] = mk(1, RIGHT,   0, 1, 0, 0, 0, 1, 0, 0, 2, 3);
      vecs[17] = mk(1, RIGHT,   0, 1, 0, 1, 1, 0, 0, 0, 2, 3);
      for (int k = 0; k < 6; k++)
         vecs[18+k] = mk(1, FORWARD, 0, 2 + k, 0, 1, 1, (k == 5), 0, 0, 0, 4 + k);
      vecs[24] = mk(1, FORWARD, 0, 7, 0, 1, 1, 1, 1, 0, 0, 9);
      vecs[25] = mk(1, FORWARD, 0, 7, 0, 1, 1, 1, 1, 0, 0, 9);
      vecs[26] = mk(1, HALT,    0, 7, 0, 1, 1, 1, 0, 0, 0, 9);

      rst_n = 1'b0; run_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_walls = '0;
      move = HALT; ph_drop = '0;
      @(posedge clk); #1;
      check("reset_pose", {26'd0, pos_x, pos_y}, {26'd0, 3'd0, 3'd0});
      check("reset_heading", 32'(heading), 32'd1);
      check("reset_flags", {28'd0, hit, escape, ant_l, ant_r}, {28'd0, 4'b0010});
      check("reset_cnt_ph", {14'd0, step_cnt, ph_detected}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         cyc(vecs[i].run, vecs[i].mv, vecs[i].drop);
         check($sformatf("vec%0d", i), obs(), pack(vecs[i]));
      end

      // Back to CONFIG: pose returns to start, commands ignored, pheromone kept.
      cyc(0, FORWARD, 1);
      check("cfg_pose", {24'd0, pos_x, pos_y, heading}, {24'd0, 3'd0, 3'd0, 2'd1});
      check("cfg_ph_kept", 32'(ph_detected), 32'd3);
      check("cfg_hit", 32'(hit), 32'd0);
      cfg_we = 1'b1; cfg_addr = 6'd1; cfg_walls = 4'b0010;
      cyc(0, HALT, 0);
      cfg_we = 1'b0;
      cyc(1, HALT, 0);
      cyc(1, FORWARD, 0);
      check("wall_pose", {26'd0, pos_x, pos_y}, {26'd0, 3'd1, 3'd0});
      check("wall_ant_r", 32'(ant_r), 32'd1);
      check("wall_ph", 32'(ph_detected), 32'd2);
      cyc(1, FORWARD, 0);
      check("wall_hit", 32'(hit), 32'd1);
      check("wall_hold", {26'd0, pos_x, pos_y}, {26'd0, 3'd1, 3'd0});

      // Asynchronous reset between edges clears everything immediately.
      #2 rst_n = 1'b0;
      #1;
      check("areset_pose", {24'd0, pos_x, pos_y, heading}, {24'd0, 3'd0, 3'd0, 2'd1});
      check("areset_flags", {30'd0, hit, escape}, 32'd0);
      check("areset_cnt", 32'(step_cnt), 32'd0);
      check("areset_ph", 32'(ph_detected), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1, HALT, 0);
      cyc(1, FORWARD, 0);
      check("areset_walls", {29'd0, pos_x, ant_r}, {29'd0, 3'd1, 1'b0});
      check("areset_ph_map", 32'(ph_detected), 32'd0);

      // Route to the exit: east along row 0, then south down column 7.
      for (int k = 0; k < 6; k++) cyc(1, FORWARD, 0);
      check("route_row", {10'd0, pos_x, pos_y, step_cnt}, {10'd0, 3'd7, 3'd0, 16'd7});
      cyc(1, RIGHT, 0);
      for (int k = 0; k < 6; k++) cyc(1, FORWARD, 0);
      check("route_pre_exit", {25'd0, pos_x, pos_y, escape}, {25'd0, 3'd7, 3'd6, 1'b0});
      cyc(1, FORWARD, 0);
      check("escape_set", {9'd0, pos_x, pos_y, escape, step_cnt}, {9'd0, 3'd7, 3'd7, 1'b1, 16'd14});
      cyc(1, FORWARD, 0);
      check("done_fwd", {7'd0, pos_x, pos_y, heading, escape, step_cnt}, {7'd0, 3'd7, 3'd7, 2'd2, 1'b1, 16'd14});
      cyc(1, RIGHT, 1);
      check("done_right", {5'd0, pos_x, pos_y, heading, escape, ph_detected, step_cnt},
            {5'd0, 3'd7, 3'd7, 2'd2, 1'b1, 2'd0, 16'd14});
      cyc(0, FORWARD, 0);
      check("done_run_off", {7'd0, pos_x, pos_y, heading, escape, step_cnt}, {7'd0, 3'd7, 3'd7, 2'd2, 1'b1, 16'd14});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
